// File: rtl/aes_multiblock_ctrl.sv
// Control FSM for a multi-block (ECB) AES job: sets up the source and sink streamers,
// runs the engine one block at a time, waits for the sink to drain, and reports done/error.
module aes_multiblock_ctrl #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WORDS_PB = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    input  logic [CNT_W-1:0]  n_blocks_i,
    output logic              src_req_start_o,
    input  logic              src_ready_start_i,
    output logic              dst_req_start_o,
    input  logic              dst_ready_start_i,
    input  logic              dst_done_i,
    output logic [ADDR_W-1:0] src_base_o,
    output logic [ADDR_W-1:0] dst_base_o,
    output logic [CNT_W+2:0]  trans_size_o,
    output logic              eng_enable_o,
    output logic              eng_clear_o,
    output logic              eng_start_o,
    output logic              eng_mode_o,
    input  logic              eng_valid_i,
    output logic [CNT_W-1:0]  blk_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned TS_W  = CNT_W + 3;
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, STARTING, BLK_START, BLK_WAIT, DRAIN, FINISHED
    } state_e;

    state_e             state_q, state_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               drained_q, drained_d;
    logic [CNT_W-1:0]   n_blocks_q;
    logic               accept_c;

    assign accept_c = (state_q == IDLE) && start_i;

    // Next-state and bookkeeping
    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        blk_cnt_d = blk_cnt_q;
        tmo_d     = tmo_q;
        drained_d = drained_q;
        case (state_q)
            IDLE: begin
                drained_d = 1'b0;
                if (start_i) begin
                    err_d     = 1'b0;
                    blk_cnt_d = '0;
                    if (n_blocks_i == '0) begin
                        err_d   = 1'b1;
                        state_d = FINISHED;
                    end else begin
                        state_d = STARTING;
                    end
                end
            end
            STARTING: begin
                if (dst_done_i) drained_d = 1'b1;
                if (src_ready_start_i && dst_ready_start_i) state_d = BLK_START;
            end
            BLK_START: begin
                if (dst_done_i) drained_d = 1'b1;
                tmo_d   = '0;
                state_d = BLK_WAIT;
            end
            BLK_WAIT: begin
                if (dst_done_i) drained_d = 1'b1;
                if (eng_valid_i) begin
                    blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    state_d   = (blk_cnt_d == n_blocks_q) ? DRAIN : BLK_START;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = FINISHED;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DRAIN: begin
                if (dst_done_i || drained_q) state_d = FINISHED;
            end
            FINISHED: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State, job latches and outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q         <= IDLE;
            err_q           <= 1'b0;
            blk_cnt_q       <= '0;
            tmo_q           <= '0;
            drained_q       <= 1'b0;
            n_blocks_q      <= '0;
            src_base_o      <= '0;
            dst_base_o      <= '0;
            trans_size_o    <= '0;
            eng_mode_o      <= 1'b0;
            src_req_start_o <= 1'b0;
            dst_req_start_o <= 1'b0;
            eng_enable_o    <= 1'b0;
            eng_clear_o     <= 1'b1;
            eng_start_o     <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            blk_cnt_q <= blk_cnt_d;
            tmo_q     <= tmo_d;
            drained_q <= drained_d;
            if (accept_c) begin
                n_blocks_q   <= n_blocks_i;
                src_base_o   <= src_base_i;
                dst_base_o   <= dst_base_i;
                trans_size_o <= TS_W'(n_blocks_i) * TS_W'(WORDS_PB);
                eng_mode_o   <= mode_i;
            end
            src_req_start_o <= (state_d == STARTING);
            dst_req_start_o <= (state_d == STARTING);
            eng_enable_o    <= (state_d == STARTING) || (state_d == BLK_START) ||
                               (state_d == BLK_WAIT) || (state_d == DRAIN);
            eng_clear_o     <= (state_d == IDLE);
            eng_start_o     <= (state_d == BLK_START);
            busy_o          <= (state_d != IDLE);
            done_o          <= (state_d == FINISHED);
        end
    end

    assign err_o     = err_q;
    assign blk_cnt_o = blk_cnt_q;

endmodule
